// File: rtl/execute_stage.sv
// Execute stage with forwarding, ALU, branch resolution, iterative shift-add
// multiplier and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int WIDTH     = 19,
  parameter int MUL_ITERS = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             Cant_ByteE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [4:0]       RDE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic             Cant_ByteM,
  output logic [4:0]       RDM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             StallE,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(MUL_ITERS + 1);
  localparam logic [4:0] SH_LIMIT = 5'(WIDTH);

  state_t           state, state_next;
  logic             stall;
  logic             is_mul;
  logic             zero;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] src_a, fwd_b, src_b, diff, alu_result;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0]    count;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b  = ALUSrcE ? ImmExtE : fwd_b;
  assign diff   = src_a - src_b;
  assign zero   = (diff == '0);
  assign shamt  = src_b[4:0];
  assign is_mul = (ALUControlE == 4'b1000);

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = diff;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = (shamt >= SH_LIMIT) ? '0 : (src_a << shamt);
      4'b0110: alu_result = (shamt >= SH_LIMIT) ? '0 : (src_a >> shamt);
      4'b0111: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mul) begin
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (count == CW'(MUL_ITERS - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall is masked by reset so upstream never freezes while we are being cleared.
  assign StallE    = stall & ~reset;
  assign PCSrcE    = ~StallE & (JumpE | (BranchE & zero));
  assign PCTargetE = PCE + ImmExtE;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (state == IDLE && is_mul) begin
      mcand  <= src_a;
      mplier <= src_b;
      acc    <= '0;
      count  <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  // EX/MEM register: bubbles clear control and destination but keep data.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      RDM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
    end else if (state == DONE) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      Cant_ByteM <= Cant_ByteE;
      RDM        <= RDE;
      ALUResultM <= acc;
    end else if (stall) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      Cant_ByteM <= 1'b0;
      RDM        <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      Cant_ByteM <= Cant_ByteE;
      RDM        <= RDE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: EX/MEM results go through an expected
// queue, combinational redirect/stall outputs are checked in-cycle.
module tb_execute_stage;

  localparam int W  = 19;
  localparam int EW = 4 + 5 + W + W;

  logic          clk = 1'b0;
  logic          reset;
  logic          RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, BranchE, JumpE, ALUSrcE;
  logic [3:0]    ALUControlE;
  logic [W-1:0]  RD1E, RD2E, ImmExtE, PCE, ResultW;
  logic [4:0]    RDE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]    RDM;
  logic [W-1:0]  ALUResultM, WriteDataM, PCTargetE;
  logic          PCSrcE, StallE;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  hold_alu, hold_wd;
  int            compared   = 0;
  int            mismatched = 0;

  typedef struct packed {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         src;
    logic [W-1:0] imm;
    logic [W-1:0] res;
  } op_t;

  execute_stage #(.WIDTH(19), .MUL_ITERS(19)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .Cant_ByteE(Cant_ByteE), .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .RDE(RDE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Cant_ByteM(Cant_ByteM), .RDM(RDM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .StallE(StallE), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic src, input logic [W-1:0] imm, input logic [4:0] rd,
                        input logic rw);
    ALUControlE = ctl; RD1E = a; RD2E = b; ALUSrcE = src; ImmExtE = imm;
    RDE = rd; RegWriteE = rw;
    MemWriteE = 1'b0; ResultSrcE = 1'b0; Cant_ByteE = 1'b0;
    BranchE = 1'b0; JumpE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00; PCE = '0;
  endtask

  task automatic expect_m(input logic rw, input logic mw, input logic rs, input logic cb,
                          input logic [4:0] rd, input logic [W-1:0] alu, input logic [W-1:0] wd);
    exp_q.push_back({rw, mw, rs, cb, rd, alu, wd});
    hold_alu = alu;
    hold_wd  = wd;
  endtask

  task automatic expect_bubble();
    exp_q.push_back({4'b0000, 5'd0, hold_alu, hold_wd});
  endtask

  task automatic step(input string tag);
    logic [EW-1:0] exp;
    tick();
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, EW'(1), EW'(0));
    end else begin
      exp = exp_q.pop_front();
      check(tag, {RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, RDM, ALUResultM, WriteDataM}, exp);
    end
  endtask

  initial begin
    op_t ops [0:13];
    ops[0]  = '{4'h2, 19'h5A5A5, 19'h0F0F3, 1'b0, 19'h00000, 19'h0A0A1};
    ops[1]  = '{4'h3, 19'h5A5A5, 19'h0F0F3, 1'b0, 19'h00000, 19'h5F5F7};
    ops[2]  = '{4'h4, 19'h5A5A5, 19'h0F0F3, 1'b0, 19'h00000, 19'h55556};
    ops[3]  = '{4'h5, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00003, 19'h52D28};
    ops[4]  = '{4'h5, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00012, 19'h40000};
    ops[5]  = '{4'h5, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00013, 19'h00000};
    ops[6]  = '{4'h6, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00004, 19'h05A5A};
    ops[7]  = '{4'h6, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00024, 19'h05A5A};
    ops[8]  = '{4'h6, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h0001F, 19'h00000};
    ops[9]  = '{4'h6, 19'h5A5A5, 19'h0F0F3, 1'b1, 19'h00012, 19'h00001};
    ops[10] = '{4'h7, 19'h7FFFF, 19'h00001, 1'b0, 19'h00000, 19'h00001};
    ops[11] = '{4'h7, 19'h00001, 19'h7FFFF, 1'b0, 19'h00000, 19'h00000};
    ops[12] = '{4'h1, 19'h00000, 19'h00001, 1'b0, 19'h00000, 19'h7FFFF};
    ops[13] = '{4'h9, 19'h5A5A5, 19'h0F0F3, 1'b0, 19'h00000, 19'h00000};

    // reset held two cycles with a MUL presented: stall must stay low
    reset = 1'b1; ResultW = '0;
    set_op(4'h8, 19'h00003, 19'h00005, 1'b0, '0, 5'd1, 1'b1);
    #1;
    check("stall_in_reset", EW'(StallE), EW'(0));
    tick();
    hold_alu = '0; hold_wd = '0;
    expect_m(0, 0, 0, 0, 5'd0, '0, '0);
    step("reset_outputs");
    check("reset_stall", EW'(StallE), EW'(0));
    check("reset_state", EW'(dbg_state), EW'(0));
    reset = 1'b0;

    // ADD with wrap
    set_op(4'h0, 19'h7FFFF, 19'h00001, 1'b0, '0, 5'd3, 1'b1);
    expect_m(1, 0, 0, 0, 5'd3, 19'h00000, 19'h00001);
    step("add_wrap");

    // store: address from immediate, data from RD2
    set_op(4'h0, 19'h00000, 19'h00003, 1'b1, 19'h00005, 5'd0, 1'b0);
    MemWriteE = 1'b1;
    expect_m(0, 1, 0, 0, 5'd0, 19'h00005, 19'h00003);
    step("store");

    // load-like control pass-through with negative immediate
    set_op(4'h0, 19'h00100, 19'h00000, 1'b1, 19'h7FFFF, 5'd2, 1'b1);
    ResultSrcE = 1'b1; Cant_ByteE = 1'b1;
    expect_m(1, 0, 1, 1, 5'd2, 19'h000FF, 19'h00000);
    step("load_ctl");

    // forwarding from ALUResultM then ResultW
    set_op(4'h0, 19'h00010, 19'h00000, 1'b0, '0, 5'd5, 1'b1);
    expect_m(1, 0, 0, 0, 5'd5, 19'h00010, 19'h00000);
    step("fwd_setup");
    set_op(4'h1, 19'h00000, 19'h00004, 1'b0, '0, 5'd6, 1'b1);
    ForwardAE = 2'b10;
    expect_m(1, 0, 0, 0, 5'd6, 19'h0000C, 19'h00004);
    step("fwd_a_mem");
    set_op(4'h1, 19'h00000, 19'h00004, 1'b0, '0, 5'd6, 1'b1);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 19'h00002;
    expect_m(1, 0, 0, 0, 5'd6, 19'h0000A, 19'h00002);
    step("fwd_b_wb");

    // ALU operation table
    for (int i = 0; i < 14; i++) begin
      set_op(ops[i].ctl, ops[i].a, ops[i].b, ops[i].src, ops[i].imm, 5'(i + 8), 1'b1);
      expect_m(1, 0, 0, 0, 5'(i + 8), ops[i].res, ops[i].b);
      step($sformatf("alu_op%0d", i));
    end

    // branch taken / not taken, jump
    set_op(4'h1, 19'h00009, 19'h00009, 1'b0, 19'h7FFFC, 5'd0, 1'b0);
    BranchE = 1'b1; PCE = 19'h00010;
    #1;
    check("br_taken", EW'(PCSrcE), EW'(1));
    check("br_target", EW'(PCTargetE), EW'(19'h0000C));
    expect_m(0, 0, 0, 0, 5'd0, 19'h00000, 19'h00009);
    step("br_taken_m");
    RD2E = 19'h00008;
    #1;
    check("br_not_taken", EW'(PCSrcE), EW'(0));
    expect_m(0, 0, 0, 0, 5'd0, 19'h00001, 19'h00008);
    step("br_not_taken_m");
    BranchE = 1'b0; JumpE = 1'b1;
    #1;
    check("jump", EW'(PCSrcE), EW'(1));
    expect_m(0, 0, 0, 0, 5'd0, 19'h00001, 19'h00008);
    step("jump_m");

    // MUL 0x123 * 0x45 with forwarding noise during the stall
    set_op(4'h8, 19'h00123, 19'h00045, 1'b0, '0, 5'd7, 1'b1);
    JumpE = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("mul_stall%0d", c), EW'({StallE, PCSrcE}), EW'(2'b10));
      expect_bubble();
      step($sformatf("mul_bubble%0d", c));
      ForwardAE = 2'b01; ForwardBE = 2'b01;
      ResultW = 19'($urandom_range(0, 19'h7FFFF));
    end
    #1;
    check("mul_done_stall", EW'(StallE), EW'(0));
    check("mul_done_state", EW'(dbg_state), EW'(2));
    expect_m(1, 0, 0, 0, 5'd7, 19'h04E6F, hold_wd);
    step("mul_result");

    // reset in cycle 7 of a MUL
    set_op(4'h8, 19'h00003, 19'h00005, 1'b0, '0, 5'd9, 1'b1);
    for (int c = 0; c < 6; c++) begin
      expect_bubble();
      step($sformatf("abort_bubble%0d", c));
    end
    reset = 1'b1;
    #1;
    check("abort_stall", EW'(StallE), EW'(0));
    hold_alu = '0; hold_wd = '0;
    expect_m(0, 0, 0, 0, 5'd0, '0, '0);
    step("abort_reset");
    reset = 1'b0;
    set_op(4'h0, 19'h00002, 19'h00003, 1'b0, '0, 5'd4, 1'b1);
    #1;
    check("post_abort_stall", EW'(StallE), EW'(0));
    expect_m(1, 0, 0, 0, 5'd4, 19'h00005, 19'h00003);
    step("post_abort_add");

    check("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
